// File: rtl/signal_distribute_pkg.sv
// signal_distribute_pkg
//   Shared definitions for the signal_distribute slice: per-slot state
//   encoding, the broadcast select code and the drop counter ceiling.
package signal_distribute_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_OVERRUN = 2'd2
  } slot_state_e;

  localparam logic [7:0]  SEL_BROADCAST = 8'hFF;
  localparam logic [15:0] DROP_MAX      = 16'hFFFF;

endpackage : signal_distribute_pkg

// File: rtl/signal_distribute_slot.sv
// signal_distribute_slot
//   One holding slot: value register, 3-state occupancy FSM and a sticky
//   overflow flag.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        store data this cycle
//   data         sample to store
//   ack          consumer has taken the held value
//   clr          clear the sticky overflow flag
//   value        last stored sample (kept after consumption)
//   available    slot holds unconsumed data
//   overflow     sticky: slot was overwritten before being consumed
module signal_distribute_slot
  import signal_distribute_pkg::*;
#(
  parameter int unsigned BITWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [BITWIDTH-1:0] data,
  input  logic                ack,
  input  logic                clr,
  output logic [BITWIDTH-1:0] value,
  output logic                available,
  output logic                overflow
);

  slot_state_e         state_q, state_d;
  logic [BITWIDTH-1:0] value_q, value_d;
  logic                ovf_q, ovf_d;
  logic                ovf_event;

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    ovf_event = 1'b0;
    if (wr_en) begin
      value_d = data;
      // An ack in the same cycle consumes the old value, so the write is
      // never an overrun in that case.
      if ((state_q != ST_EMPTY) && !ack) begin
        state_d   = ST_OVERRUN;
        ovf_event = 1'b1;
      end else begin
        state_d = ST_FULL;
      end
    end else if (ack) begin
      state_d = ST_EMPTY;
    end
    // Clear wins over a coincident overflow event.
    ovf_d = clr ? 1'b0 : (ovf_q | ovf_event);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value     = value_q;
  assign available = (state_q != ST_EMPTY);
  assign overflow  = ovf_q;

endmodule : signal_distribute_slot

// File: rtl/signal_distribute.sv
// signal_distribute
//   Routes one sample stream to one of CHANNELS holding slots addressed by
//   channel_select. Each slot keeps its value and raises available_out[k]
//   until acknowledged. Out-of-range samples are dropped and counted.
// Configuration
//   SIGNAL_DISTRIBUTE_BROADCAST_EN: when defined, select code 8'hFF writes
//   the sample to every slot; otherwise 8'hFF is an ordinary dropped code.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   signal_in       sample to distribute
//   available_in    sample-valid strobe
//   channel_select  destination slot
//   read_ack        per-channel consume strobe
//   clear_overflow  clears overflow flags and drop_count
//   signal_out      slot values, channel k at [k*BITWIDTH +: BITWIDTH]
//   available_out   per-slot unconsumed-data flag
//   overflow        per-slot sticky overwrite flag
//   drop_count      saturating count of out-of-range samples
module signal_distribute
  import signal_distribute_pkg::*;
#(
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned CHANNELS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BITWIDTH-1:0]          signal_in,
  input  logic                         available_in,
  input  logic [7:0]                   channel_select,
  input  logic [CHANNELS-1:0]          read_ack,
  input  logic                         clear_overflow,
  output logic [BITWIDTH*CHANNELS-1:0] signal_out,
  output logic [CHANNELS-1:0]          available_out,
  output logic [CHANNELS-1:0]          overflow,
  output logic [15:0]                  drop_count
);

  logic                is_bcast;
  logic                sel_in_range;
  logic                drop;
  logic [CHANNELS-1:0] wr_vec;
  logic [15:0]         drop_q, drop_d;

`ifdef SIGNAL_DISTRIBUTE_BROADCAST_EN
  assign is_bcast = (channel_select == SEL_BROADCAST);
`else
  assign is_bcast = 1'b0;
`endif

  always_comb begin
    sel_in_range = (32'(channel_select) < CHANNELS);
    drop         = available_in && !sel_in_range && !is_bcast;
    wr_vec       = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_vec[i] = available_in && (is_bcast || (channel_select == 8'(i)));
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (clear_overflow) begin
      drop_d = drop ? 16'd1 : '0;
    end else if (drop && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_count = drop_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    signal_distribute_slot #(
      .BITWIDTH(BITWIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_vec[k]),
      .data     (signal_in),
      .ack      (read_ack[k]),
      .clr      (clear_overflow),
      .value    (signal_out[k*BITWIDTH +: BITWIDTH]),
      .available(available_out[k]),
      .overflow (overflow[k])
    );
  end

endmodule : signal_distribute

// File: tb/tb_signal_distribute.sv
module tb_signal_distribute;

  localparam int BW = 16;
  localparam int CH = 8;
`ifdef SIGNAL_DISTRIBUTE_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [BW-1:0]      signal_in;
  logic               available_in;
  logic [7:0]         channel_select;
  logic [CH-1:0]      read_ack;
  logic               clear_overflow;
  logic [BW*CH-1:0]   signal_out;
  logic [CH-1:0]      available_out;
  logic [CH-1:0]      overflow;
  logic [15:0]        drop_count;

  signal_distribute #(.BITWIDTH(BW), .CHANNELS(CH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .signal_in     (signal_in),
    .available_in  (available_in),
    .channel_select(channel_select),
    .read_ack      (read_ack),
    .clear_overflow(clear_overflow),
    .signal_out    (signal_out),
    .available_out (available_out),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW*CH-1:0] so;
    logic [CH-1:0]    av;
    logic [CH-1:0]    ov;
    logic [15:0]      dc;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference model: 0 empty, 1 full, 2 overrun
  logic [BW-1:0] m_val [CH];
  int            m_st  [CH];
  logic [CH-1:0] m_ovf;
  logic [15:0]   m_drop;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin m_val[i] = '0; m_st[i] = 0; end
    m_ovf  = '0;
    m_drop = '0;
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    for (int i = 0; i < CH; i++) begin
      e.so[i*BW +: BW] = m_val[i];
      e.av[i]          = (m_st[i] != 0);
    end
    e.ov = m_ovf;
    e.dc = m_drop;
    return e;
  endfunction

  // Drive one cycle at the negedge, advance the model, push the expected
  // post-edge state; the monitor compares it just after the posedge.
  task automatic drive_cycle(input logic v, input logic [7:0] sel,
                             input logic [BW-1:0] d, input logic [CH-1:0] ack,
                             input logic clr);
    bit hit_b, in_rng, ev;
    @(negedge clk);
    available_in   = v;
    channel_select = sel;
    signal_in      = d;
    read_ack       = ack;
    clear_overflow = clr;
    hit_b  = BCAST && (sel == 8'hFF);
    in_rng = (int'(sel) < CH);
    for (int i = 0; i < CH; i++) begin
      ev = 1'b0;
      if (v && (hit_b || int'(sel) == i)) begin
        m_val[i] = d;
        if (m_st[i] != 0 && !ack[i]) begin m_st[i] = 2; ev = 1'b1; end
        else m_st[i] = 1;
      end else if (ack[i]) begin
        m_st[i] = 0;
      end
      if (clr) m_ovf[i] = 1'b0;
      else if (ev) m_ovf[i] = 1'b1;
    end
    if (v && !in_rng && !hit_b) begin
      if (clr) m_drop = 16'd1;
      else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end else if (clr) begin
      m_drop = '0;
    end
    sb_q.push_back(model_snapshot());
    @(posedge clk);
    #2;
    available_in   = 1'b0;
    read_ack       = '0;
    clear_overflow = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_chk++;
      if (signal_out !== e.so) begin
        n_err++;
        $display("FAIL sb_signal_out got=%h exp=%h", signal_out, e.so);
      end
      n_chk++;
      if (available_out !== e.av) begin
        n_err++;
        $display("FAIL sb_available got=%h exp=%h", available_out, e.av);
      end
      n_chk++;
      if (overflow !== e.ov) begin
        n_err++;
        $display("FAIL sb_overflow got=%h exp=%h", overflow, e.ov);
      end
      n_chk++;
      if (drop_count !== e.dc) begin
        n_err++;
        $display("FAIL sb_drop_count got=%h exp=%h", drop_count, e.dc);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    available_in = 1'b0; channel_select = '0; signal_in = '0;
    read_ack = '0; clear_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({signal_out, available_out, overflow, drop_count} !== '0) begin
      n_err++;
      $display("FAIL reset_state got=%h/%h/%h/%h exp=0", signal_out, available_out, overflow, drop_count);
    end
    @(negedge clk); rst_n = 1'b1;
    // Mid-stream: fill two slots, record a drop, then assert reset between edges.
    drive_cycle(1'b1, 8'd0, 16'h1111, '0, 1'b0);
    drive_cycle(1'b1, 8'd1, 16'h2222, '0, 1'b0);
    drive_cycle(1'b1, 8'd9, 16'h3333, '0, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({signal_out, available_out, overflow, drop_count} !== '0) begin
      n_err++;
      $display("FAIL async_reset got=%h/%h/%h/%h exp=0", signal_out, available_out, overflow, drop_count);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    drive_cycle(1'b1, 8'd3, 16'hABCD, '0, 1'b0);
    n_chk++;
    if (signal_out[63:48] !== 16'hABCD || available_out !== 8'h08) begin
      n_err++;
      $display("FAIL ch3_write got=%h/%h exp=abcd/08", signal_out[63:48], available_out);
    end
    drive_cycle(1'b0, 8'd0, 16'h0000, 8'h08, 1'b0);
    n_chk++;
    if (available_out !== 8'h00 || signal_out[63:48] !== 16'hABCD) begin
      n_err++;
      $display("FAIL ch3_ack got=%h/%h exp=00/abcd", available_out, signal_out[63:48]);
    end
  endtask

  task automatic test_overflow();
    drive_cycle(1'b1, 8'd5, 16'h0001, '0, 1'b0);
    drive_cycle(1'b1, 8'd5, 16'h0002, '0, 1'b0);
    n_chk++;
    if (signal_out[95:80] !== 16'h0002 || overflow !== 8'h20) begin
      n_err++;
      $display("FAIL ch5_overrun got=%h/%h exp=0002/20", signal_out[95:80], overflow);
    end
    drive_cycle(1'b0, 8'd0, 16'h0000, 8'h20, 1'b0);
    n_chk++;
    if (available_out[5] !== 1'b0 || overflow !== 8'h20) begin
      n_err++;
      $display("FAIL ch5_ack_sticky got=%b/%h exp=0/20", available_out[5], overflow);
    end
    drive_cycle(1'b0, 8'd0, 16'h0000, '0, 1'b1);
    n_chk++;
    if (overflow !== 8'h00) begin
      n_err++;
      $display("FAIL ch5_clear got=%h exp=00", overflow);
    end
  endtask

  task automatic test_write_ack_same();
    drive_cycle(1'b1, 8'd2, 16'h1234, '0, 1'b0);
    drive_cycle(1'b1, 8'd2, 16'h5678, 8'h04, 1'b0);
    n_chk++;
    if (signal_out[47:32] !== 16'h5678 || available_out[2] !== 1'b1 || overflow[2] !== 1'b0) begin
      n_err++;
      $display("FAIL ch2_wr_ack got=%h/%b/%b exp=5678/1/0", signal_out[47:32], available_out[2], overflow[2]);
    end
    drive_cycle(1'b0, 8'd0, 16'h0000, 8'h04, 1'b0);
    drive_cycle(1'b0, 8'd0, 16'h0000, 8'h04, 1'b0); // ack while empty: ignored
  endtask

  task automatic test_drop();
    logic [BW*CH-1:0] so_before;
    so_before = signal_out;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'd9, 16'hDEAD, '0, 1'b0);
    n_chk++;
    if (drop_count !== 16'd3 || signal_out !== so_before) begin
      n_err++;
      $display("FAIL drop_three got=%0d exp=3", drop_count);
    end
    @(negedge clk);
    available_in = 1'b1; channel_select = 8'd9; signal_in = 16'hBEEF;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    available_in = 1'b0;
    m_drop = 16'hFFFF;
    n_chk++;
    if (drop_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL drop_saturate got=%h exp=ffff", drop_count);
    end
    drive_cycle(1'b1, 8'd200, 16'hBEEF, '0, 1'b0);
    drive_cycle(1'b1, 8'd9, 16'hBEEF, '0, 1'b1); // clear with coincident drop -> 1
    n_chk++;
    if (drop_count !== 16'd1) begin
      n_err++;
      $display("FAIL drop_clear_coincide got=%0d exp=1", drop_count);
    end
  endtask

  task automatic test_broadcast();
    logic [BW*CH-1:0] so_before;
    logic [15:0]      dc_before;
    for (int i = 0; i < CH; i++) drive_cycle(1'b0, 8'd0, 16'h0000, 8'hFF, 1'b0);
    so_before = signal_out;
    dc_before = drop_count;
    drive_cycle(1'b1, 8'hFF, 16'h5A5A, '0, 1'b0);
    n_chk++;
    if (BCAST) begin
      if (signal_out !== {CH{16'h5A5A}} || available_out !== 8'hFF || drop_count !== dc_before) begin
        n_err++;
        $display("FAIL broadcast got=%h/%h/%h exp=all 5a5a/ff/%h", signal_out, available_out, drop_count, dc_before);
      end
    end else begin
      if (signal_out !== so_before || available_out !== 8'h00 || drop_count !== dc_before + 16'd1) begin
        n_err++;
        $display("FAIL broadcast_off got=%h/%h exp=00/%h", available_out, drop_count, dc_before + 16'd1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sel;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        8:       sel = 8'd9;
        9:       sel = 8'hFF;
        default: sel = 8'($urandom_range(0, CH - 1));
      endcase
      drive_cycle(1'($urandom_range(0, 3) != 0), sel, 16'($urandom),
                  8'($urandom), 1'($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_write_ack_same();
    test_drop();
    test_broadcast();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_signal_distribute
